// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared state encoding and frame geometry for the life pass sequencer
package life_pkg;

    typedef logic [2:0] life_ctrl_state_t;

    localparam life_ctrl_state_t ST_IDLE  = 3'd0;
    localparam life_ctrl_state_t ST_INIT  = 3'd1;
    localparam life_ctrl_state_t ST_PASS  = 3'd2;
    localparam life_ctrl_state_t ST_DRAIN = 3'd3;
    localparam life_ctrl_state_t ST_VID   = 3'd4;

    // Each engine generation needs one extra torus row before and after the frame.
    function automatic int lead_rows(input int gens);
        return gens;
    endfunction

    function automatic int frame_rows(input int dbits);
        return 1 << (dbits - 1);
    endfunction

endpackage

// File: rtl/life_wr_delay.sv
// rtl/life_wr_delay.sv - aligns write enable/row with engine output, PIPE_LAT cycles after read issue
module life_wr_delay
    import life_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int RBITS    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [RBITS-1:0] in_row,
    output logic             out_valid,
    output logic [RBITS-1:0] out_row
);

    logic [PIPE_LAT-1:0] valid_q;
    logic [RBITS-1:0]    row_q [PIPE_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) row_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            row_q[0]   <= in_row;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                row_q[i]   <= row_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[PIPE_LAT-1];
    assign out_row   = row_q[PIPE_LAT-1];

endmodule

// File: rtl/life_pass_ctrl.sv
// rtl/life_pass_ctrl.sv - generation pass sequencer, host init loader and video row arbiter for life_engine
module life_pass_ctrl
    import life_pkg::*;
#(
    parameter int DBITS    = 8,
    parameter int WIDTH    = 256,
    parameter int GENS     = 1,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    output logic             busy,
    output logic             pass_done,
    output logic [31:0]      gen_count,
    input  logic             init_valid,
    output logic             init_ready,
    input  logic [WIDTH-1:0] init_row,
    input  logic             vid_req,
    input  logic [DBITS-2:0] vid_row,
    output logic             vid_ack,
    output logic [DBITS-1:0] raddr,
    output logic [DBITS-1:0] waddr,
    output logic             we,
    output logic             sh,
    output logic             ld,
    output logic             init,
    output logic [WIDTH-1:0] init_data
);

    localparam int RBITS      = DBITS - 1;
    localparam int KBITS      = DBITS + 1;
    localparam int FRAME_ROWS = frame_rows(DBITS);
    localparam int LEAD       = lead_rows(GENS);

    localparam logic [RBITS-1:0] ROW_LAST  = RBITS'(FRAME_ROWS - 1);
    localparam logic [KBITS-1:0] K_LAST_RD = KBITS'(FRAME_ROWS + 2*LEAD - 1);
    localparam logic [KBITS-1:0] K_LAST_WR = KBITS'(FRAME_ROWS + 2*LEAD + PIPE_LAT - 1);

    life_ctrl_state_t state_q, state_d;
    logic [KBITS-1:0] k_q, k_d;
    logic [RBITS-1:0] row_q, row_d;
    logic             src_bank_q, src_bank_d;
    logic [31:0]      gen_count_q, gen_count_d;
    logic             vid_pend_q, vid_pend_d;
    logic [RBITS-1:0] vid_row_q, vid_row_d;
    logic [2:0]       vid_sr_q;
    logic [WIDTH-1:0] init_data_q;

    logic             vid_any, vid_take, last_wr;
    logic             wr_in_valid, wr_valid;
    logic [RBITS-1:0] wr_in_row, wr_row, rd_row;

    assign vid_any = vid_req | vid_pend_q;
    assign last_wr = (state_q == ST_DRAIN) && (k_q == K_LAST_WR);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        src_bank_d  = src_bank_q;
        gen_count_d = gen_count_q;
        vid_take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (init_valid)         state_d = ST_INIT;
                else if (start || run)  state_d = ST_PASS;
                else if (vid_any) begin
                    state_d  = ST_VID;
                    vid_take = 1'b1;
                end
            end
            ST_INIT: begin
                if (init_valid) begin
                    row_d = row_q + RBITS'(1);
                    if (row_q == ROW_LAST) state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                k_d = k_q + KBITS'(1);
                if (k_q == K_LAST_RD) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                k_d = k_q + KBITS'(1);
                if (last_wr) begin
                    gen_count_d = gen_count_q + 32'(GENS);
                    src_bank_d  = ~src_bank_q;
                    k_d         = '0;
                    // Waiting host/video work goes ahead of an auto-restart so run cannot starve it.
                    if (init_valid)   state_d = ST_INIT;
                    else if (vid_any) begin
                        state_d  = ST_VID;
                        vid_take = 1'b1;
                    end
                    else if (run)     state_d = ST_PASS;
                    else              state_d = ST_IDLE;
                end
            end
            ST_VID:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign vid_pend_d = vid_take ? 1'b0 : (vid_req ? 1'b1 : vid_pend_q);
    assign vid_row_d  = (vid_req && !vid_pend_q) ? vid_row : vid_row_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            row_q       <= '0;
            src_bank_q  <= 1'b0;
            gen_count_q <= '0;
            vid_pend_q  <= 1'b0;
            vid_row_q   <= '0;
            vid_sr_q    <= '0;
            init_data_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            src_bank_q  <= src_bank_d;
            gen_count_q <= gen_count_d;
            vid_pend_q  <= vid_pend_d;
            vid_row_q   <= vid_row_d;
            vid_sr_q    <= {vid_sr_q[1:0], ld};
            init_data_q <= init_valid ? init_row : init_data_q;
        end
    end

    assign sh          = (state_q == ST_PASS);
    assign ld          = (state_q == ST_VID);
    assign rd_row      = RBITS'(k_q - KBITS'(LEAD));
    assign wr_in_valid = sh && (k_q >= KBITS'(2*LEAD));
    assign wr_in_row   = RBITS'(k_q - KBITS'(2*LEAD));

    life_wr_delay #(
        .PIPE_LAT (PIPE_LAT),
        .RBITS    (RBITS)
    ) u_wr_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wr_in_valid),
        .in_row    (wr_in_row),
        .out_valid (wr_valid),
        .out_row   (wr_row)
    );

    assign busy       = (state_q != ST_IDLE);
    assign pass_done  = last_wr;
    assign gen_count  = gen_count_q;
    assign init_ready = (state_q == ST_INIT) && init_valid;
    assign init       = init_ready;
    assign init_data  = init_data_q;
    assign vid_ack    = vid_sr_q[2];
    assign we         = wr_valid | init_ready;
    assign waddr      = init_ready ? {src_bank_q, row_q} :
                        (wr_valid  ? {~src_bank_q, wr_row} : '0);
    assign raddr      = sh ? {src_bank_q, rd_row} :
                        (ld ? {src_bank_q, vid_row_q} : '0);

endmodule

// File: tb/tb_life_pass_ctrl.sv
// tb/tb_life_pass_ctrl.sv - scoreboard bench for life_pass_ctrl against a frame-level pass model
module tb_life_pass_ctrl;

    localparam int DBITS    = 8;
    localparam int WIDTH    = 256;
    localparam int GENS     = 1;
    localparam int PIPE_LAT = 4;
    localparam int FR       = 1 << (DBITS - 1);
    localparam int LEAD     = GENS;
    localparam int BOUND    = 3000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             run = 1'b0;
    logic             init_valid = 1'b0;
    logic             vid_req = 1'b0;
    logic [WIDTH-1:0] init_row = '0;
    logic [DBITS-2:0] vid_row = '0;
    logic             busy, pass_done, init_ready, vid_ack, we, sh, ld, init;
    logic [31:0]      gen_count;
    logic [DBITS-1:0] raddr, waddr;
    logic [WIDTH-1:0] init_data;

    always #5 clk = ~clk;

    life_pass_ctrl #(
        .DBITS(DBITS), .WIDTH(WIDTH), .GENS(GENS), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .run(run), .busy(busy),
        .pass_done(pass_done), .gen_count(gen_count), .init_valid(init_valid),
        .init_ready(init_ready), .init_row(init_row), .vid_req(vid_req),
        .vid_row(vid_row), .vid_ack(vid_ack), .raddr(raddr), .waddr(waddr),
        .we(we), .sh(sh), .ld(ld), .init(init), .init_data(init_data)
    );

    typedef struct {
        logic [DBITS-1:0] addr;
        logic             is_init;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic [DBITS-1:0] rd_q[$];
    wr_t              wr_q[$];
    logic [DBITS-1:0] vid_q[$];
    logic [31:0]      done_q[$];
    int               ld_cyc[$];

    int checks = 0, errors = 0, cyc = 0, done_seen = 0;
    logic             m_src = 1'b0;
    logic [31:0]      m_gen = '0;
    logic             data_pend = 1'b0, gen_pend = 1'b0, ack_exp;
    logic [WIDTH-1:0] data_exp;
    logic [31:0]      gen_exp;
    wr_t              mon_w;
    logic [DBITS-1:0] mon_a;

    function automatic void chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
    endfunction

    function automatic void flush();
        rd_q.delete(); wr_q.delete(); vid_q.delete(); done_q.delete(); ld_cyc.delete();
        data_pend = 1'b0;
        gen_pend  = 1'b0;
    endfunction

    // One pass, frame view: torus reads with LEAD rows of wrap either side, every row written to the other bank.
    function automatic void exp_pass();
        for (int k = 0; k < FR + 2*LEAD; k++)
            rd_q.push_back({m_src, (DBITS-1)'((k - LEAD + FR) % FR)});
        for (int r = 0; r < FR; r++)
            wr_q.push_back('{addr: {~m_src, (DBITS-1)'(r)}, is_init: 1'b0, data: '0});
        m_gen = m_gen + GENS;
        done_q.push_back(m_gen);
        m_src = ~m_src;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (data_pend) begin chk("init_data", init_data, data_exp); data_pend = 1'b0; end
            if (gen_pend)  begin chk("gen_count", WIDTH'(gen_count), WIDTH'(gen_exp)); gen_pend = 1'b0; end
            if (sh) begin
                if (rd_q.size() > 0) begin mon_a = rd_q.pop_front(); chk("raddr", WIDTH'(raddr), WIDTH'(mon_a)); end
                else unexpected("sh");
            end
            if (we) begin
                if (wr_q.size() > 0) begin
                    mon_w = wr_q.pop_front();
                    chk("waddr", WIDTH'(waddr), WIDTH'(mon_w.addr));
                    chk("init", WIDTH'(init), WIDTH'(mon_w.is_init));
                    if (mon_w.is_init) begin data_pend = 1'b1; data_exp = mon_w.data; end
                end else unexpected("we");
            end
            ack_exp = (ld_cyc.size() > 0) && (ld_cyc[0] + 3 == cyc);
            if (ack_exp) void'(ld_cyc.pop_front());
            if (ack_exp || vid_ack) chk("vid_ack", WIDTH'(vid_ack), WIDTH'(ack_exp));
            if (ld) begin
                chk("ld_exclusive", WIDTH'(sh | we), '0);
                if (vid_q.size() > 0) begin mon_a = vid_q.pop_front(); chk("vid_raddr", WIDTH'(raddr), WIDTH'(mon_a)); end
                else unexpected("ld");
                ld_cyc.push_back(cyc);
            end
            if (pass_done) begin
                done_seen++;
                if (done_q.size() > 0) begin gen_exp = done_q.pop_front(); gen_pend = 1'b1; end
                else unexpected("pass_done");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input string tag);
        int t;
        t = 0;
        while (((rd_q.size() + wr_q.size() + vid_q.size() + done_q.size() + ld_cyc.size()) != 0 || busy)
               && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (t >= BOUND) begin
            errors++;
            $display("FAIL settle_%s: still pending after %0d cycles rd=%0d wr=%0d vid=%0d done=%0d busy=%0b",
                     tag, t, rd_q.size(), wr_q.size(), vid_q.size(), done_q.size(), busy);
            flush();
        end
        tick();
    endtask

    task automatic do_pass(input bit dup_start);
        exp_pass();
        start = 1'b1; tick(); start = 1'b0;
        if (dup_start) begin
            repeat (20) tick();
            start = 1'b1; tick(); start = 1'b0;
        end
        settle("pass");
    endtask

    task automatic do_init(input bit gaps, input bit with_start);
        for (int r = 0; r < FR; r++) begin
            logic [WIDTH-1:0] d;
            int t;
            for (int i = 0; i < WIDTH/32; i++) d[i*32 +: 32] = $urandom();
            wr_q.push_back('{addr: {m_src, (DBITS-1)'(r)}, is_init: 1'b1, data: d});
            if (gaps) while ($urandom_range(0, 3) == 0) begin init_valid = 1'b0; tick(); end
            init_valid = 1'b1;
            init_row   = d;
            if (with_start && r == 0) start = 1'b1;
            t = 0;
            @(negedge clk);
            while (!init_ready && t < 50) begin @(negedge clk); t++; end
            tick();
            start = 1'b0;
            if (t >= 50) begin
                checks++; errors++;
                $display("FAIL init_ready: row %0d not accepted within 50 cycles", r);
                init_valid = 1'b0;
                flush();
                return;
            end
        end
        init_valid = 1'b0;
        settle("init");
    endtask

    task automatic do_vid(input logic [DBITS-2:0] row);
        vid_q.push_back({m_src, row});
        vid_req = 1'b1; vid_row = row; tick(); vid_req = 1'b0;
        settle("vid");
    endtask

    task automatic do_run(input int n);
        int base, t;
        for (int i = 0; i < n; i++) exp_pass();
        base = done_seen;
        t = 0;
        run = 1'b1;
        tick();
        while (done_seen < base + n - 1 && t < n * 400) begin @(negedge clk); t++; end
        tick();
        run = 1'b0;
        settle("run");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", WIDTH'(busy), '0);
        chk("rst_pass_done", WIDTH'(pass_done), '0);
        chk("rst_gen_count", WIDTH'(gen_count), '0);
        chk("rst_init_ready", WIDTH'(init_ready), '0);
        chk("rst_vid_ack", WIDTH'(vid_ack), '0);
        chk("rst_raddr", WIDTH'(raddr), '0);
        chk("rst_waddr", WIDTH'(waddr), '0);
        chk("rst_we", WIDTH'(we), '0);
        chk("rst_sh", WIDTH'(sh), '0);
        chk("rst_ld", WIDTH'(ld), '0);
        chk("rst_init", WIDTH'(init), '0);
        chk("rst_init_data", init_data, '0);
        tick();
        reset = 1'b1;
        tick();

        do_init(1'b0, 1'b1);
        do_pass(1'b1);
        do_run(3);

        exp_pass();
        vid_q.push_back({m_src, (DBITS-1)'(5)});
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        vid_req = 1'b1; vid_row = 5; tick(); vid_req = 1'b0;
        settle("vid_defer");

        do_vid((DBITS-1)'($urandom_range(0, FR - 1)));

        if (!m_src) do_pass(1'b0);
        exp_pass();
        start = 1'b1; tick(); start = 1'b0;
        repeat ($urandom_range(10, 120)) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", WIDTH'(busy), '0);
        chk("mid_rst_sh", WIDTH'(sh), '0);
        chk("mid_rst_we", WIDTH'(we), '0);
        chk("mid_rst_raddr", WIDTH'(raddr), '0);
        chk("mid_rst_waddr", WIDTH'(waddr), '0);
        chk("mid_rst_gen_count", WIDTH'(gen_count), '0);
        flush();
        m_src = 1'b0;
        m_gen = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
        do_pass(1'b0);

        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0: do_init(1'b1, 1'b0);
                1: do_pass(1'b0);
                2: do_vid((DBITS-1)'($urandom_range(0, FR - 1)));
                default: do_run($urandom_range(2, 3));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
